// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core / DMA) arbiter onto a single-port data memory with locked DMA bursts.
// Optional: define DMEM_ARB_CORE_PRIO_EN for fixed core priority; round-robin otherwise.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              stall_core,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    typedef enum logic {ARB, DLOCK} state_t;
    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              last_d, c_pend, d_pend;
    logic [DATA_W-1:0] c_rdata_q, d_rdata_q;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        c_gnt    = 1'b0;
        d_gnt    = 1'b0;
        if (!reset) begin
            if (state == ARB) begin
`ifdef DMEM_ARB_CORE_PRIO_EN
                c_gnt = c_req;
`else
                c_gnt = c_req & (~d_req | last_d);
`endif
                d_gnt = d_req & ~c_gnt;
                if (d_gnt && d_lock && MAX_BURST > 1) begin
                    state_nx = DLOCK;
                    cnt_nx   = CNT_W'(1);
                end
            end else begin
                d_gnt  = d_req;
                cnt_nx = d_gnt ? cnt + 1'b1 : cnt;
                if (!d_lock || !d_req || cnt_nx == CNT_W'(MAX_BURST))
                    state_nx = ARB;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB;
            cnt       <= '0;
            last_d    <= 1'b1;
            c_pend    <= 1'b0;
            d_pend    <= 1'b0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            last_d    <= c_gnt ? 1'b0 : d_gnt ? 1'b1 : last_d;
            c_pend    <= c_gnt & ~c_we;
            d_pend    <= d_gnt & ~d_we;
            c_rdata_q <= c_rvalid ? mem_rd_data : c_rdata_q;
            d_rdata_q <= d_rvalid ? mem_rd_data : d_rdata_q;
        end
    end
    // read data is forwarded straight from memory on the valid cycle, then held
    assign c_rvalid    = c_pend & ~reset;
    assign d_rvalid    = d_pend & ~reset;
    assign c_rdata     = c_rvalid ? mem_rd_data : c_rdata_q;
    assign d_rdata     = d_rvalid ? mem_rd_data : d_rdata_q;
    assign stall_core  = c_req & ~c_gnt;
    assign mem_wr      = (c_gnt & c_we) | (d_gnt & d_we);
    assign mem_rd      = (c_gnt & ~c_we) | (d_gnt & ~d_we);
    assign mem_addr    = c_gnt ? c_addr : d_gnt ? d_addr : '0;
    assign mem_wr_data = c_gnt ? c_wdata : d_gnt ? d_wdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table of requests/expected grants, with a read-data scoreboard.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_CORE_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b1;
    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0, d_lock = 0;
    logic [8:0]  c_addr = 0, d_addr = 0;
    logic [31:0] c_wdata = 0, d_wdata = 0;
    logic        c_gnt, c_rvalid, stall_core, d_gnt, d_rvalid, mem_wr, mem_rd;
    logic [31:0] c_rdata, d_rdata, mem_wr_data, mem_rd_data = 0;
    logic [8:0]  mem_addr;
    logic [31:0] mem [0:511];
    logic [31:0] ref_mem [0:511];

    typedef struct {
        bit rst, cr, cw; logic [8:0] ca; logic [31:0] cd;
        bit dr, dw, dl; logic [8:0] da; logic [31:0] dd;
        bit ecg, edg;
    } vec_t;
    typedef struct { bit own_d; logic [31:0] data; } rd_t;
    vec_t vt[$];
    rd_t  sb[$];
    int   n_cmp = 0, n_bad = 0, row = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .MAX_BURST(8)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .stall_core(stall_core),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wr_data;
        mem_rd_data <= mem_rd ? mem[mem_addr] : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    function automatic void add(input bit rst, input bit cr, input bit cw, input logic [8:0] ca,
                                input logic [31:0] cd, input bit dr, input bit dw, input bit dl,
                                input logic [8:0] da, input logic [31:0] dd, input bit ecg, input bit edg);
        vec_t v;
        v = '{rst, cr, cw, ca, cd, dr, dw, dl, da, dd, ecg, edg};
        vt.push_back(v);
    endfunction

    initial begin
        rd_t e;
        bit exp_crv, exp_drv, wr, rd, ecg_b;
        logic [31:0] exp_data, c_last, d_last, wd;
        logic [8:0] ad;
        for (int i = 0; i < 512; i++) begin
            mem[i] = 32'hA5A5_0000 ^ i;
            ref_mem[i] = 32'hA5A5_0000 ^ i;
        end
        mem[16] = 32'hDEAD_BEEF;
        ref_mem[16] = 32'hDEAD_BEEF;
        // reset with requests, reset state, core read, DMA write then read-back
        add(1, 1, 0, 9'h010, 0, 1, 0, 0, 9'h011, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 9'h010, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 9'h1FF, 32'h1234_5678, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 9'h1FF, 0, 0, 1);
        add(0, 1, 0, 9'h020, 0, 0, 0, 0, 0, 0, 1, 0);
        // reset cancels the pending core read, then four contended cycles
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            ecg_b = PRIO || (i % 2 == 0);
            add(0, 1, 0, 9'(9'h030 + i), 0, 1, 0, 0, 9'(9'h040 + i), 0, ecg_b, !ecg_b);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // locked DMA burst of 12 requested beats while the core waits
        add(0, 0, 0, 0, 0, 1, 1, 1, 9'h100, 32'hB000_0000, 0, 1);
        for (int i = 1; i < 12; i++) begin
            ecg_b = (i == 8) || (i > 8 && PRIO);
            add(0, 1, 0, 9'(9'h050 + i), 0, 1, 1, 1, 9'(9'h100 + i), 32'hB000_0000 + i,
                ecg_b, !ecg_b);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset right after a DMA read grant
        add(0, 0, 0, 0, 0, 1, 0, 0, 9'h100, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset in the middle of a lock drops it
        add(0, 0, 0, 0, 0, 1, 1, 1, 9'h150, 32'hC000_0000, 0, 1);
        add(0, 1, 0, 9'h060, 0, 1, 1, 1, 9'h151, 32'hC000_0001, 0, 1);
        add(1, 1, 0, 9'h060, 0, 1, 1, 1, 9'h152, 32'hC000_0002, 0, 0);
        add(0, 1, 0, 9'h150, 0, 1, 1, 1, 9'h152, 32'hC000_0002, 1, 0);
        add(0, 1, 0, 9'h061, 0, 1, 0, 0, 9'h151, 0, PRIO, !PRIO);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // lock released early by d_lock=0
        add(0, 0, 0, 0, 0, 1, 0, 1, 9'h070, 0, 0, 1);
        add(0, 1, 1, 9'h080, 32'hEEEE_0001, 1, 0, 0, 9'h071, 0, 0, 1);
        add(0, 1, 1, 9'h080, 32'hEEEE_0001, 1, 0, 0, 9'h072, 0, 1, 0);
        add(0, 1, 0, 9'h080, 0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        c_last = 0;
        d_last = 0;
        foreach (vt[k]) begin
            row = k;
            @(negedge clk);
            reset = vt[k].rst; c_req = vt[k].cr; c_we = vt[k].cw; c_addr = vt[k].ca;
            c_wdata = vt[k].cd; d_req = vt[k].dr; d_we = vt[k].dw; d_lock = vt[k].dl;
            d_addr = vt[k].da; d_wdata = vt[k].dd;
            #1;
            exp_crv = 0; exp_drv = 0; exp_data = 0;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_crv = !vt[k].rst && !e.own_d;
                exp_drv = !vt[k].rst && e.own_d;
                exp_data = e.data;
            end
            chk("c_rvalid", 32'(c_rvalid), 32'(exp_crv));
            chk("d_rvalid", 32'(d_rvalid), 32'(exp_drv));
            chk("c_rdata", c_rdata, exp_crv ? exp_data : c_last);
            chk("d_rdata", d_rdata, exp_drv ? exp_data : d_last);
            c_last = vt[k].rst ? 32'h0 : exp_crv ? exp_data : c_last;
            d_last = vt[k].rst ? 32'h0 : exp_drv ? exp_data : d_last;
            wr = (vt[k].ecg && vt[k].cw) || (vt[k].edg && vt[k].dw);
            rd = (vt[k].ecg && !vt[k].cw) || (vt[k].edg && !vt[k].dw);
            ad = vt[k].ecg ? vt[k].ca : vt[k].edg ? vt[k].da : 9'h0;
            wd = vt[k].ecg ? vt[k].cd : vt[k].edg ? vt[k].dd : 32'h0;
            chk("c_gnt", 32'(c_gnt), 32'(vt[k].ecg));
            chk("d_gnt", 32'(d_gnt), 32'(vt[k].edg));
            chk("stall_core", 32'(stall_core), 32'(vt[k].cr && !vt[k].ecg));
            chk("mem_wr", 32'(mem_wr), 32'(wr));
            chk("mem_rd", 32'(mem_rd), 32'(rd));
            chk("mem_addr", 32'(mem_addr), 32'(ad));
            chk("mem_wr_data", mem_wr_data, wd);
            if (rd) begin
                e.own_d = vt[k].edg;
                e.data = ref_mem[ad];
                sb.push_back(e);
            end
            if (wr) ref_mem[ad] = wd;
        end
        row = vt.size();
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, giving the data width.
REQ-002 The block SHALL have the parameter ADDR_W, default 9, giving the data memory address width.
REQ-003 The block SHALL have the parameter MAX_BURST, default 8, giving the maximum number of beats in one locked DMA grant.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high. The ports are:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- c_req  in  1  core access request
- c_we  in  1  core write (1) / read (0)
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_gnt  out  1  core access issued this cycle
- c_rvalid  out  1  core read data valid
- c_rdata  out  DATA_W  core read data
- stall_core  out  1  c_req & ~c_gnt
- d_req  in  1  DMA/debug request
- d_we  in  1  DMA write (1) / read (0)
- d_lock  in  1  DMA requests a burst lock
- d_addr  in  ADDR_W  DMA address
- d_wdata  in  DATA_W  DMA write data
- d_gnt  out  1  DMA access issued this cycle
- d_rvalid  out  1  DMA read data valid
- d_rdata  out  DATA_W  DMA read data
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid 1 cycle after mem_rd

Function
REQ-005 At most one of c_gnt/d_gnt SHALL be high per cycle; a grant is combinational from the current request and registered state, and the access is issued in the same cycle.
REQ-006 mem_wr SHALL equal gnt & we and mem_rd SHALL equal gnt & ~we of the granted requester; mem_addr and mem_wr_data SHALL mux the granted requester's values; with no grant, all memory outputs SHALL be 0.
REQ-007 A granted read SHALL assert the owner's rvalid exactly one cycle later, with rdata equal to mem_rd_data; the other requester's rdata SHALL hold its last value.
REQ-008 The FSM SHALL have two states, ARB and DLOCK.
REQ-009 In ARB with one requester active, that requester SHALL be granted.
REQ-010 In ARB with both requesters active, arbitration SHALL follow the configured policy (REQ-016/REQ-017).
REQ-011 The FSM SHALL move ARB->DLOCK when d_gnt & d_lock; the beat counter SHALL then load 1.
REQ-012 In DLOCK, d_gnt SHALL equal d_req and c_gnt SHALL be 0; each d_gnt SHALL increment the counter.
REQ-013 The FSM SHALL move DLOCK->ARB when d_lock=0 or d_req=0, or after the beat that makes the counter equal MAX_BURST. On a MAX_BURST exit the last-grant pointer SHALL be DMA, so that a waiting core wins the next cycle under either policy.
REQ-014 The last-grant pointer SHALL update on every grant.
REQ-015 Simultaneous requests SHALL never drop an access: the requester that is not granted sees gnt=0 and holds its request.

Configuration
REQ-016 With macro DMEM_ARB_CORE_PRIO_EN defined, the core SHALL always win simultaneous requests in ARB; DLOCK and MAX_BURST still apply.
REQ-017 Without DMEM_ARB_CORE_PRIO_EN, simultaneous requests in ARB SHALL be granted round-robin: the requester not granted most recently wins.

Reset
REQ-018 On reset the block SHALL set state to ARB, counter to 0, the last-grant pointer to DMA, c_rvalid/d_rvalid to 0, and c_rdata/d_rdata to 0.
REQ-019 While reset is high, c_gnt, d_gnt, mem_wr and mem_rd SHALL be 0.
REQ-020 A reset asserted during an outstanding read or a DLOCK burst SHALL cancel the pending rvalid and drop the lock in the following cycle.

Verification
REQ-021 Core read only: c_req=1, c_we=0, c_addr=0x010, mem returns 0xDEADBEEF -> c_gnt=1, mem_rd=1, mem_addr=0x010 at cycle T; c_rvalid=1, c_rdata=0xDEADBEEF at T+1.
REQ-022 Both request for 4 cycles, macro undefined -> grants alternate C,D,C,D; stall_core=1 on D cycles.
REQ-023 Both request, macro defined -> c_gnt=1 on every cycle, d_gnt=0 throughout.
REQ-024 DMA locked burst (d_lock=1, d_req=1, 12 cycles, MAX_BURST=8) with core requesting -> d_gnt for 8 consecutive cycles, then c_gnt=1 on cycle 9.
REQ-025 Reset on the cycle after a DMA read grant -> d_rvalid=0 in the following cycle, state ARB, all strobes 0.
REQ-026 DMA write d_addr=0x1FF, d_wdata=0x12345678 -> mem_wr=1, mem_addr=0x1FF, mem_wr_data=0x12345678, no rvalid.
